// File: rtl/matmul_seq_engine.sv
// Sequential C = A x B engine: one multiply-accumulate per cycle, row-major element order.
// Optional macro MATMUL_SATURATE_EN clamps each C element to the signed DATA_W range.
module matmul_seq_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 4,
  parameter int unsigned ACC_W  = 72
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  output logic              a_rd_en,
  output logic [DIM_W-1:0]  a_row,
  output logic [DIM_W-1:0]  a_col,
  input  logic [DATA_W-1:0] a_data,
  output logic              b_rd_en,
  output logic [DIM_W-1:0]  b_row,
  output logic [DIM_W-1:0]  b_col,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_wr_en,
  output logic [DIM_W-1:0]  c_row,
  output logic [DIM_W-1:0]  c_col,
  output logic [DATA_W-1:0] c_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sat_flag
);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWrite, StFinish} state_e;

  localparam logic [DIM_W-1:0] IdxOne = DIM_W'(1);

  state_e                   state_q, state_d;
  logic [DIM_W-1:0]         dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [DIM_W-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
  logic                     done_q, done_d, err_q, err_d;
  logic [DIM_W-1:0]         a_row_q, a_row_d, a_col_q, a_col_d;
  logic [DIM_W-1:0]         b_row_q, b_row_d, b_col_q, b_col_d;
  logic [DIM_W-1:0]         c_row_q, c_row_d, c_col_q, c_col_d;
  logic [DATA_W-1:0]        c_data_q, c_data_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     vld_q, vld_d, first_q, first_d;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]        res;
  logic                     start_accept;

  assign start_accept = (state_q == StIdle) && start;
  assign prod         = $signed(a_data) * $signed(b_data);

  // Operands return one cycle after issue, so the pair is tagged with its issue-time k==0.
  assign vld_d   = (state_q == StFetch);
  assign first_d = (state_q == StFetch) && (k_q == '0);

  always_comb begin
    acc_d = acc_q;
    if (vld_q) begin
      acc_d = (first_q ? '0 : acc_q) + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic clamp;
  logic sat_q, sat_d;

  always_comb begin
    res   = acc_d[DATA_W-1:0];
    clamp = 1'b0;
    if (acc_d > SatMax) begin
      res   = SatMax[DATA_W-1:0];
      clamp = 1'b1;
    end else if (acc_d < SatMin) begin
      res   = SatMin[DATA_W-1:0];
      clamp = 1'b1;
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (start_accept) begin
      sat_d = 1'b0;
    end else if ((state_d == StWrite) && clamp) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) sat_q <= 1'b0;
    else          sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  assign res      = acc_d[DATA_W-1:0];
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dim_m_d = dim_m_q;
    dim_k_d = dim_k_q;
    dim_n_d = dim_n_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dim_m_d = dim_m;
          dim_k_d = dim_k;
          dim_n_d = dim_n;
          if ((dim_m == '0) || (dim_k == '0) || (dim_n == '0)) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            done_d  = 1'b0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (k_q == dim_k_q - IdxOne) state_d = StDrain;
        else                         k_d     = k_q + IdxOne;
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        k_d     = '0;
        state_d = StFetch;
        if (j_q == dim_n_q - IdxOne) begin
          j_d = '0;
          if (i_q == dim_m_q - IdxOne) state_d = StFinish;
          else                         i_d     = i_q + IdxOne;
        end else begin
          j_d = j_q + IdxOne;
        end
      end
      StFinish: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Index/data outputs are registered and only move when their strobe is about to assert.
  always_comb begin
    a_row_d  = a_row_q;
    a_col_d  = a_col_q;
    b_row_d  = b_row_q;
    b_col_d  = b_col_q;
    c_row_d  = c_row_q;
    c_col_d  = c_col_q;
    c_data_d = c_data_q;
    if (state_d == StFetch) begin
      a_row_d = i_d;
      a_col_d = k_d;
      b_row_d = k_d;
      b_col_d = j_d;
    end
    if (state_d == StWrite) begin
      c_row_d  = i_d;
      c_col_d  = j_d;
      c_data_d = res;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      a_row_q  <= '0;
      a_col_q  <= '0;
      b_row_q  <= '0;
      b_col_q  <= '0;
      c_row_q  <= '0;
      c_col_q  <= '0;
      c_data_q <= '0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dim_m_q  <= dim_m_d;
      dim_k_q  <= dim_k_d;
      dim_n_q  <= dim_n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      a_row_q  <= a_row_d;
      a_col_q  <= a_col_d;
      b_row_q  <= b_row_d;
      b_col_q  <= b_col_d;
      c_row_q  <= c_row_d;
      c_col_q  <= c_col_d;
      c_data_q <= c_data_d;
      acc_q    <= acc_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
    end
  end

  assign a_rd_en = (state_q == StFetch);
  assign b_rd_en = (state_q == StFetch);
  assign c_wr_en = (state_q == StWrite);
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;
  assign a_row   = a_row_q;
  assign a_col   = a_col_q;
  assign b_row   = b_row_q;
  assign b_col   = b_col_q;
  assign c_row   = c_row_q;
  assign c_col   = c_col_q;
  assign c_data  = c_data_q;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Bench for matmul_seq_engine: table of small jobs with hand-derived C, plus reset/zero-dim,
// start-while-busy and random model-checked jobs; C writes are scored against a queue.
module tb_matmul_seq_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  dim_m = '0, dim_k = '0, dim_n = '0;
  logic        a_rd_en, b_rd_en, c_wr_en, busy, done, err, sat_flag;
  logic [3:0]  a_row, a_col, b_row, b_col, c_row, c_col;
  logic [31:0] a_data = '0, b_data = '0, c_data;

  always #5 clk = ~clk;

  matmul_seq_engine #(.DATA_W(32), .DIM_W(4), .ACC_W(72)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .a_rd_en(a_rd_en), .a_row(a_row), .a_col(a_col), .a_data(a_data),
    .b_rd_en(b_rd_en), .b_row(b_row), .b_col(b_col), .b_data(b_data),
    .c_wr_en(c_wr_en), .c_row(c_row), .c_col(c_col), .c_data(c_data),
    .busy(busy), .done(done), .err(err), .sat_flag(sat_flag)
  );

  // A/B storage owned by the front end; data valid one cycle after the read strobe.
  logic [31:0] mem_a [16][16];
  logic [31:0] mem_b [16][16];
  always @(posedge clk) begin
    a_data <= a_rd_en ? mem_a[a_row][a_col] : 32'hDEAD_BEEF;
    b_data <= b_rd_en ? mem_b[b_row][b_col] : 32'hBAAD_F00D;
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic void check(string name, longint act, longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  typedef struct packed {
    logic [3:0]  r;
    logic [3:0]  c;
    logic [31:0] d;
  } wr_t;
  wr_t sb[$];

  int rd_cnt = 0;
  int wr_cnt = 0;
  wr_t e;

  always @(negedge clk) begin
    if (a_rd_en) rd_cnt++;
    if (a_rd_en || b_rd_en) check("b_rd_en_pair", b_rd_en, a_rd_en);
    if (a_rd_en || b_rd_en || c_wr_en) check("strobe_busy", busy, 1);
    if (c_wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("c_wr_unexpected", c_wr_en, 0);
      end else begin
        e = sb.pop_front();
        check("c_row", c_row, e.r);
        check("c_col", c_col, e.c);
        check("c_data", c_data, e.d);
      end
    end
  end

  typedef struct packed {
    int          m;
    int          k;
    int          n;
    logic [8:0][31:0] a;
    logic [8:0][31:0] b;
    logic [8:0][31:0] c;
    logic        s;
  } vec_t;
  vec_t vt[$];
  int ta[9], tb[9], tc[9];

  task automatic add(int m, int k, int n, bit s);
    vec_t v;
    v.m = m; v.k = k; v.n = n; v.s = s;
    for (int x = 0; x < 9; x++) begin
      v.a[x] = ta[x];
      v.b[x] = tb[x];
      v.c[x] = tc[x];
    end
    vt.push_back(v);
  endtask

  task automatic load_vec(vec_t v);
    for (int i = 0; i < v.m; i++)
      for (int kk = 0; kk < v.k; kk++) mem_a[i][kk] = v.a[i*v.k+kk];
    for (int kk = 0; kk < v.k; kk++)
      for (int j = 0; j < v.n; j++) mem_b[kk][j] = v.b[kk*v.n+j];
    for (int i = 0; i < v.m; i++)
      for (int j = 0; j < v.n; j++) sb.push_back('{r: 4'(i), c: 4'(j), d: v.c[i*v.n+j]});
  endtask

  // Independent reference: full-width signed dot products, then clamp or truncate.
  task automatic load_random(int m, int k, int n, bit full, output bit s);
    logic signed [71:0] acc;
    logic signed [63:0] p;
    logic [31:0]        d;
    s = 1'b0;
    for (int i = 0; i < m; i++)
      for (int kk = 0; kk < k; kk++)
        mem_a[i][kk] = full ? $urandom : 32'(int'($urandom_range(0, 200)) - 100);
    for (int kk = 0; kk < k; kk++)
      for (int j = 0; j < n; j++)
        mem_b[kk][j] = full ? $urandom : 32'(int'($urandom_range(0, 200)) - 100);
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = '0;
        for (int kk = 0; kk < k; kk++) begin
          p   = $signed(mem_a[i][kk]) * $signed(mem_b[kk][j]);
          acc = acc + {{8{p[63]}}, p};
        end
        d = acc[31:0];
`ifdef MATMUL_SATURATE_EN
        if (acc > 72'sh7FFF_FFFF) begin
          d = 32'h7FFF_FFFF; s = 1'b1;
        end else if (acc < -72'sh8000_0000) begin
          d = 32'h8000_0000; s = 1'b1;
        end
`endif
        sb.push_back('{r: 4'(i), c: 4'(j), d: d});
      end
    end
  endtask

  task automatic run_job(string name, int m, int k, int n, bit exp_sat, bit poke);
    int cyc, busy_cyc, rd0, wr0, lat;
    lat = m * n * (k + 2) + 2;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    dim_m = 4'(m); dim_k = 4'(k); dim_n = 4'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dim_m = '0; dim_k = '0; dim_n = '0;
    cyc = 1;
    busy_cyc = 0;
    while (!done && cyc < lat + 50) begin
      if (busy) busy_cyc++;
      start = (poke && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({name, "_latency"}, cyc, lat);
    check({name, "_busy_cycles"}, busy_cyc, lat - 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_err"}, err, 0);
    check({name, "_reads"}, rd_cnt - rd0, m * n * k);
    check({name, "_writes"}, wr_cnt - wr0, m * n);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_sat"}, sat_flag, exp_sat);
    @(posedge clk); #1;
    check({name, "_done_level"}, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, n_v;
    bit s;

    ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    tc = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
    add(2, 2, 2, 1'b0);
    ta = '{-1, 2, -3, 4, -5, 6, 0, 0, 0};
    tb = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    tc = '{-2, 5, 0, 0, 0, 0, 0, 0, 0};
    add(2, 3, 1, 1'b0);
    ta = '{-7, 0, 0, 0, 0, 0, 0, 0, 0};
    tb = '{6, 0, 0, 0, 0, 0, 0, 0, 0};
    tc = '{-42, 0, 0, 0, 0, 0, 0, 0, 0};
    add(1, 1, 1, 1'b0);
    ta = '{2, -1, 0, 0, 0, 0, 0, 0, 0};
    tb = '{1, 2, 3, 4, 5, 6, 0, 0, 0};
    tc = '{-2, -1, 0, 0, 0, 0, 0, 0, 0};
    add(1, 2, 3, 1'b0);
    ta = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0};
    tb = '{2, 2, 0, 0, 0, 0, 0, 0, 0};
`ifdef MATMUL_SATURATE_EN
    tc = '{32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    add(1, 2, 1, 1'b1);
`else
    tc = '{32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0};
    add(1, 2, 1, 1'b0);
`endif
    ta = '{32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0};
    tb = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
`ifdef MATMUL_SATURATE_EN
    tc = '{32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0};
    add(1, 2, 1, 1'b1);
`else
    tc = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    add(1, 2, 1, 1'b0);
`endif
    ta = '{1, -2, 3, 0, 0, 0, 0, 0, 0};
    tb = '{10, -20, 0, 0, 0, 0, 0, 0, 0};
    tc = '{10, -20, -20, 40, 30, -60, 0, 0, 0};
    add(3, 1, 2, 1'b0);

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {a_rd_en, b_rd_en, c_wr_en, busy, done, err, sat_flag}, 0);
    check("rst_idx", {a_row, a_col, b_row, b_col, c_row, c_col}, 0);
    check("rst_c_data", c_data, 0);
    rst = 1'b0;

    // Zero-dimension requests in each position.
    for (int z = 0; z < 3; z++) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(posedge clk); #1;
      dim_m = (z == 0) ? 4'd0 : 4'd2;
      dim_k = (z == 1) ? 4'd0 : 4'd2;
      dim_n = (z == 2) ? 4'd0 : 4'd2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("zero_err", err, 1);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      check("zero_reads", rd_cnt - rd0, 0);
      check("zero_writes", wr_cnt - wr0, 0);
      check("zero_still_idle", busy, 0);
    end

    n_v = vt.size();
    for (int v = 0; v < n_v; v++) begin
      load_vec(vt[v]);
      run_job($sformatf("vec%0d", v), vt[v].m, vt[v].k, vt[v].n, vt[v].s, 1'b0);
    end

    // Start pulsed (with zero dims) while busy must be ignored.
    load_vec(vt[0]);
    run_job("poke", 2, 2, 2, 1'b0, 1'b1);

    // Reset during the second element's FETCH.
    load_vec(vt[0]);
    @(posedge clk); #1;
    dim_m = 4'd2; dim_k = 4'd2; dim_n = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_in_fetch", a_rd_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_flags", {a_rd_en, b_rd_en, c_wr_en, busy, done, err, sat_flag}, 0);
    check("midrst_idx", {a_row, a_col, b_row, b_col, c_row, c_col}, 0);
    check("midrst_c_data", c_data, 0);
    sb.delete();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_reads", rd_cnt - rd0, 0);
    check("midrst_no_writes", wr_cnt - wr0, 0);
    load_vec(vt[0]);
    run_job("after_rst", 2, 2, 2, 1'b0, 1'b0);

    load_random(3, 4, 5, 1'b0, s);
    run_job("rand_small", 3, 4, 5, s, 1'b0);
    load_random(15, 15, 15, 1'b1, s);
    run_job("rand_full", 15, 15, 15, s, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
